dmem_responder: RTL and testbench

- Data-memory slave answering the processor's dmem port (`address_dmem`, `data`, `wren` in; `q_dmem` out).
- Holds a word-addressed RAM and a small MMIO window.
- The MMIO window exposes an inbound pixel FIFO fed by the image source and an outbound pixel register drained by the image sink.
- Sits in the wrapper between the processor and the image I/O path.

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: processor dmem slave with a word RAM and an MMIO pixel window (inbound FIFO, outbound register).
// Optional STATS counters are built only when DMEM_STATS_EN is defined.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] MMIO_TAG   = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  input  logic        pix_in_valid,
  input  logic [31:0] pix_in_data,
  output logic        pix_in_ready,
  output logic        pix_out_valid,
  output logic [31:0] pix_out_data,
  input  logic        pix_out_ready
);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CW        = PW + 1;
  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]   ram [RAM_DEPTH];
  logic [31:0]   ram_q;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   prev_addr;
  logic [31:0]   mmio_q;
  logic          rd_ram;

  logic          is_mmio;
  logic [15:0]   off;
  logic          sel_data, sel_status, sel_out, sel_stats;
  logic          empty, full, flush, push, pop, out_wr, out_load;
  logic [31:0]   status_word, stats_word, mmio_rdata;

  always_comb begin
    is_mmio    = (address_dmem[31:16] == MMIO_TAG);
    off        = address_dmem[15:0];
    sel_data   = is_mmio && (off == 16'd0);
    sel_status = is_mmio && (off == 16'd1);
    sel_out    = is_mmio && (off == 16'd2);
    sel_stats  = is_mmio && (off == 16'd3);
    empty      = (count == '0);
    full       = (count == CW'(FIFO_DEPTH));
    flush      = wren && sel_status && data[0];
    push       = pix_in_valid && !full && !flush;
    // Pop only on the first cycle of a PIX_DATA load; a held address does not drain the FIFO.
    pop        = sel_data && !wren && (address_dmem != prev_addr) && !empty;
    out_wr     = wren && sel_out;
    out_load   = out_wr && (!pix_out_valid || pix_out_ready);
  end

  assign pix_in_ready = !full;

  always_comb begin
    status_word           = '0;
    status_word[0]        = empty;
    status_word[1]        = full;
    status_word[2]        = pix_out_valid;
    status_word[8 +: CW]  = count;
  end

  always_comb begin
    mmio_rdata = '0;
    if (sel_data)        mmio_rdata = empty ? 32'd0 : fifo_mem[rd_ptr];
    else if (sel_status) mmio_rdata = status_word;
    else if (sel_out)    mmio_rdata = pix_out_data;
    else if (sel_stats)  mmio_rdata = stats_word;
  end

  // Read-before-write falls out of sampling the old word in the same edge as the store.
  always_ff @(posedge clock) begin
    if (wren && !is_mmio) ram[address_dmem[ADDR_WIDTH-1:0]] <= data;
    ram_q <= ram[address_dmem[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= pix_in_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_addr     <= '0;
      rd_ram        <= 1'b0;
      mmio_q        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pix_out_valid <= 1'b0;
      pix_out_data  <= '0;
    end else begin
      prev_addr <= address_dmem;
      rd_ram    <= !is_mmio;
      mmio_q    <= is_mmio ? mmio_rdata : 32'd0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      if (out_load) begin
        pix_out_data  <= data;
        pix_out_valid <= 1'b1;
      end else if (pix_out_ready) begin
        pix_out_valid <= 1'b0;
      end
    end
  end

  assign q_dmem = rd_ram ? ram_q : mmio_q;

`ifdef DMEM_STATS_EN
  logic [15:0] drop_cnt, fr_cnt;

  always_ff @(posedge clock) begin
    if (!reset || (wren && sel_stats)) begin
      drop_cnt <= '0;
      fr_cnt   <= '0;
    end else begin
      if (out_wr && !out_load && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (pix_in_valid && (full || flush) && (fr_cnt != 16'hFFFF)) fr_cnt <= fr_cnt + 16'd1;
    end
  end

  assign stats_word = {drop_cnt, fr_cnt};
`else
  assign stats_word = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios then randomized traffic against a queue-based model.
module tb_dmem_responder;
  localparam int          DEPTH = 16;
  localparam logic [31:0] MM    = 32'hFFFF_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic        pix_in_valid = 1'b0;
  logic [31:0] pix_in_data = '0;
  logic        pix_in_ready;
  logic        pix_out_valid;
  logic [31:0] pix_out_data;
  logic        pix_out_ready = 1'b0;

  always #5 clock = ~clock;

  dmem_responder dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .pix_in_valid(pix_in_valid), .pix_in_data(pix_in_data),
    .pix_in_ready(pix_in_ready), .pix_out_valid(pix_out_valid), .pix_out_data(pix_out_data),
    .pix_out_ready(pix_out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] m_fifo[$];
  logic [31:0] m_ram[int];
  logic [31:0] m_prev = '0, m_out_data = '0, m_q = '0;
  bit          m_out_valid = 0, m_q_known = 1;
  int          m_drop = 0, m_fr = 0;

  function automatic logic [31:0] m_status();
    int n = m_fifo.size();
    return (32'(n) << 8) | (32'(m_out_valid) << 2) | (32'(n == DEPTH) << 1) | 32'(n == 0);
  endfunction

  function automatic logic [31:0] m_stats();
`ifdef DMEM_STATS_EN
    return {m_drop[15:0], m_fr[15:0]};
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    address_dmem = a;
    data         = d;
    wren         = w;
  endtask

  // Advance one clock: apply the model to the inputs in force at the edge, then compare outputs.
  task automatic step();
    bit          ready, mm, flush, pop, out_wr;
    logic [15:0] off;
    int          ridx;
    if (!reset) begin
      m_fifo.delete();
      m_out_valid = 0; m_out_data = '0; m_prev = '0;
      m_drop = 0; m_fr = 0; m_q = '0; m_q_known = 1;
    end else begin
      ready = (m_fifo.size() != DEPTH);
      mm    = (address_dmem[31:16] == 16'hFFFF);
      off   = address_dmem[15:0];
      ridx  = int'(address_dmem[11:0]);
      m_q_known = 1;
      if (mm) begin
        case (off)
          16'd0:   m_q = (m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
          16'd1:   m_q = m_status();
          16'd2:   m_q = m_out_data;
          16'd3:   m_q = m_stats();
          default: m_q = 32'd0;
        endcase
      end else if (m_ram.exists(ridx)) begin
        m_q = m_ram[ridx];
      end else begin
        m_q_known = 0;
      end
      flush  = wren && mm && (off == 16'd1) && data[0];
      pop    = mm && (off == 16'd0) && !wren && (address_dmem != m_prev) && (m_fifo.size() > 0);
      out_wr = wren && mm && (off == 16'd2);
      if (pix_in_valid && (!ready || flush) && m_fr < 65535) m_fr++;
      if (out_wr && m_out_valid && !pix_out_ready && m_drop < 65535) m_drop++;
      if (wren && mm && (off == 16'd3)) begin m_drop = 0; m_fr = 0; end
      if (flush) m_fifo.delete();
      else begin
        if (pop) void'(m_fifo.pop_front());
        if (pix_in_valid && ready) m_fifo.push_back(pix_in_data);
      end
      if (out_wr && (!m_out_valid || pix_out_ready)) begin
        m_out_data = data; m_out_valid = 1;
      end else if (pix_out_ready) m_out_valid = 0;
      if (wren && !mm) m_ram[ridx] = data;
      m_prev = address_dmem;
    end
    @(posedge clock); #1;
    if (m_q_known) check("q_dmem", q_dmem, m_q);
    check("out_valid", 32'(pix_out_valid), 32'(m_out_valid));
    check("out_data", pix_out_data, m_out_data);
    check("in_ready", 32'(pix_in_ready), 32'(m_fifo.size() != DEPTH));
  endtask

  initial begin
    drive(32'd5, 32'd0, 1'b0);
    step(); step();
    reset = 1'b1;
    check("rst_q", q_dmem, 32'd0);
    drive(MM | 32'd1, 32'd0, 1'b0); step();
    check("rst_status", q_dmem, 32'h1);

    drive(32'd5, 32'hDEADBEEF, 1'b1); step();
    drive(32'd5, 32'd0, 1'b0); step();
    check("ram_rd", q_dmem, 32'hDEADBEEF);
    drive(32'd5 + 32'd4096, 32'd0, 1'b0); step();
    check("ram_alias", q_dmem, 32'hDEADBEEF);
    drive(32'd6, 32'd1, 1'b1); step();
    drive(32'd6, 32'd2, 1'b1); step();
    check("ram_rbw", q_dmem, 32'd1);

    drive(32'd5, 32'd0, 1'b0);
    pix_in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin pix_in_data = 32'(i); step(); end
    pix_in_data = 32'd17;
    drive(MM | 32'd1, 32'd0, 1'b0); step();
    check("fill_full", 32'(q_dmem[1]), 32'd1);
    check("fill_count", 32'(q_dmem[12:8]), 32'd16);
    check("fill_ready", 32'(pix_in_ready), 32'd0);
    step();
    check("fill_held", 32'(q_dmem[12:8]), 32'd16);
    pix_in_valid = 1'b0;

    for (int i = 1; i <= 16; i++) begin
      drive(MM, 32'd0, 1'b0); step();
      check("drain", q_dmem, 32'(i));
      drive(MM | 32'd1, 32'd0, 1'b0); step();
    end
    check("drain_empty", 32'(q_dmem[0]), 32'd1);
    drive(MM, 32'd0, 1'b0); step();
    check("empty_pop", q_dmem, 32'd0);

    drive(MM | 32'd2, 32'hAA, 1'b1); step();
    check("out_load_v", 32'(pix_out_valid), 32'd1);
    check("out_load_d", pix_out_data, 32'hAA);
    drive(MM | 32'd2, 32'hBB, 1'b1); step();
    check("out_drop", pix_out_data, 32'hAA);
`ifdef DMEM_STATS_EN
    drive(MM | 32'd3, 32'd0, 1'b0); step();
    check("stats_drop", 32'(q_dmem[31:16]), 32'd1);
`endif
    pix_out_ready = 1'b1;
    drive(32'd5, 32'd0, 1'b0); step();
    check("out_drain", 32'(pix_out_valid), 32'd0);
    pix_out_ready = 1'b0;

    pix_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin pix_in_data = 32'(100 + i); step(); end
    pix_in_valid = 1'b0;
    drive(MM | 32'd2, 32'h77, 1'b1); step();
    drive(32'd5, 32'd0, 1'b0);
    reset = 1'b0; step(); reset = 1'b1;
    check("mid_rst_valid", 32'(pix_out_valid), 32'd0);
    check("mid_rst_q", q_dmem, 32'd0);
    drive(MM | 32'd1, 32'd0, 1'b0); step();
    check("mid_rst_status", q_dmem, 32'h1);
    drive(32'd5, 32'd0, 1'b0); step();
    check("mid_rst_ram", q_dmem, 32'hDEADBEEF);

    pix_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin pix_in_data = 32'(200 + i); step(); end
    pix_in_data = 32'd99;
    drive(MM | 32'd1, 32'd1, 1'b1); step();
    pix_in_valid = 1'b0;
    drive(MM | 32'd1, 32'd0, 1'b0); step();
    check("flush_status", q_dmem, 32'h1);
    drive(MM, 32'd0, 1'b0); step();
    check("flush_pop", q_dmem, 32'd0);

    for (int i = 0; i < 8; i++) begin drive(32'(i), $urandom, 1'b1); step(); end
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a, d;
      if ($urandom_range(0, 1) == 0) a = MM | 32'($urandom_range(0, 5));
      else a = (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 7));
      d = $urandom;
      if (a == (MM | 32'd1)) d[0] = ($urandom_range(0, 5) == 0);
      drive(a, d, ($urandom_range(0, 3) == 0));
      pix_in_valid  = ($urandom_range(0, 1) == 1);
      pix_in_data   = $urandom;
      pix_out_ready = ($urandom_range(0, 2) == 0);
      reset         = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
